// File: rtl/aemb_dwb_pkg.sv
// Shared definitions for the AEMB data-bus load/store unit: FSM encoding,
// byte-select codes and small select classifiers.
package aemb_dwb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dwb_state_t;

    // Big-endian lane numbering: LANE3 is bits [31:24].
    localparam logic [3:0] SEL_LANE3 = 4'h8;
    localparam logic [3:0] SEL_LANE2 = 4'h4;
    localparam logic [3:0] SEL_LANE1 = 4'h2;
    localparam logic [3:0] SEL_LANE0 = 4'h1;
    localparam logic [3:0] SEL_HALF1 = 4'hC;
    localparam logic [3:0] SEL_HALF0 = 4'h3;
    localparam logic [3:0] SEL_WORD  = 4'hF;
    localparam logic [3:0] SEL_NONE  = 4'h0;

    function automatic logic sel_is_byte(input logic [3:0] sel);
        return (sel == SEL_LANE3) || (sel == SEL_LANE2) ||
               (sel == SEL_LANE1) || (sel == SEL_LANE0);
    endfunction

    function automatic logic sel_is_half(input logic [3:0] sel);
        return (sel == SEL_HALF1) || (sel == SEL_HALF0);
    endfunction

    // A zero select is the FSL encoding and never starts a bus cycle.
    function automatic logic is_mem_req(input logic ld, input logic st,
                                        input logic [3:0] sel);
        return (ld || st) && (sel != SEL_NONE);
    endfunction

endpackage

// File: rtl/aemb_dwb_align.sv
// Combinational data steering: replicates store operands across byte lanes
// and aligns/zero-extends load data from the selected lanes.
module aemb_dwb_align
    import aemb_dwb_pkg::*;
(
    input  logic [3:0]  st_sel,
    input  logic [31:0] st_dat,
    output logic [31:0] st_rep,
    input  logic [3:0]  ld_sel,
    input  logic [31:0] ld_dat,
    output logic [31:0] ld_ext
);

    logic st_byte;
    logic st_half;

    assign st_byte = sel_is_byte(st_sel);
    assign st_half = sel_is_half(st_sel);

    // Each lane picks the low byte, the matching byte of the low half, or its own byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_rep[gi*8 +: 8] = st_byte ? st_dat[7:0] :
                                       st_half ? st_dat[(gi % 2)*8 +: 8] :
                                                 st_dat[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        ld_ext = 32'd0;
        case (ld_sel)
            SEL_LANE3: ld_ext = {24'd0, ld_dat[31:24]};
            SEL_LANE2: ld_ext = {24'd0, ld_dat[23:16]};
            SEL_LANE1: ld_ext = {24'd0, ld_dat[15:8]};
            SEL_LANE0: ld_ext = {24'd0, ld_dat[7:0]};
            SEL_HALF1: ld_ext = {16'd0, ld_dat[31:16]};
            SEL_HALF0: ld_ext = {16'd0, ld_dat[15:0]};
            SEL_WORD:  ld_ext = ld_dat;
            default:   ld_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/aemb_dwb_lsu.sv
// AEMB load/store unit: one Wishbone data cycle per load/store, pipeline
// stall via gena, load result alignment and an ack watchdog.
module aemb_dwb_lsu
    import aemb_dwb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int TOW = 8
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          req_ld_i,
    input  logic          req_st_i,
    input  logic [DW-1:2] req_adr_i,
    input  logic [3:0]    req_sel_i,
    input  logic [31:0]   req_dat_i,
    output logic [DW-1:2] dwb_adr_o,
    output logic [3:0]    dwb_sel_o,
    output logic          dwb_stb_o,
    output logic          dwb_wre_o,
    output logic [31:0]   dwb_dat_o,
    input  logic [31:0]   dwb_dat_i,
    input  logic          dwb_ack_i,
    output logic          gena,
    output logic [31:0]   rDWBDI,
    output logic          rDWBERR
);

    localparam logic [TOW-1:0] CNT_MAX = '1;

    dwb_state_t      state_reg;
    logic [TOW-1:0]  cnt_reg;
    logic [TOW-1:0]  cnt_next;
    logic [DW-1:2]   adr_reg;
    logic [3:0]      sel_reg;
    logic            stb_reg;
    logic            wre_reg;
    logic [31:0]     dat_reg;
    logic            gena_reg;
    logic [31:0]     dwbdi_reg;
    logic            err_reg;

    logic [31:0]     st_rep;
    logic [31:0]     ld_ext;
    logic            mem_req;

    aemb_dwb_align u_align (
        .st_sel (req_sel_i),
        .st_dat (req_dat_i),
        .st_rep (st_rep),
        .ld_sel (sel_reg),
        .ld_dat (dwb_dat_i),
        .ld_ext (ld_ext)
    );

    assign mem_req  = is_mem_req(req_ld_i, req_st_i, req_sel_i);
    assign cnt_next = cnt_reg + TOW'(1);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            adr_reg   <= '0;
            sel_reg   <= SEL_NONE;
            stb_reg   <= 1'b0;
            wre_reg   <= 1'b0;
            dat_reg   <= 32'd0;
            gena_reg  <= 1'b1;
            dwbdi_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_req) begin
                        adr_reg   <= req_adr_i;
                        sel_reg   <= req_sel_i;
                        wre_reg   <= req_st_i;
                        dat_reg   <= st_rep;
                        stb_reg   <= 1'b1;
                        gena_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ack is examined first so an ack on the timeout edge completes normally.
                    if (dwb_ack_i) begin
                        stb_reg   <= 1'b0;
                        gena_reg  <= 1'b1;
                        if (!wre_reg) begin
                            dwbdi_reg <= ld_ext;
                        end
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == CNT_MAX) begin
                            stb_reg   <= 1'b0;
                            gena_reg  <= 1'b1;
                            dwbdi_reg <= 32'd0;
                            err_reg   <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // The request still on the inputs is the one just finished.
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    stb_reg   <= 1'b0;
                    gena_reg  <= 1'b1;
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign dwb_adr_o = adr_reg;
    assign dwb_sel_o = sel_reg;
    assign dwb_stb_o = stb_reg;
    assign dwb_wre_o = wre_reg;
    assign dwb_dat_o = dat_reg;
    assign gena      = gena_reg;
    assign rDWBDI    = dwbdi_reg;
    assign rDWBERR   = err_reg;

endmodule

// File: tb/tb_aemb_dwb_lsu.sv
// Directed bench for aemb_dwb_lsu with a hand-driven Wishbone slave (TOW=4).
module tb_aemb_dwb_lsu;

    logic        gclk = 1'b0;
    logic        grst;
    logic        req_ld_i;
    logic        req_st_i;
    logic [31:2] req_adr_i;
    logic [3:0]  req_sel_i;
    logic [31:0] req_dat_i;
    logic [31:2] dwb_adr_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_stb_o;
    logic        dwb_wre_o;
    logic [31:0] dwb_dat_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;
    logic        gena;
    logic [31:0] rDWBDI;
    logic        rDWBERR;

    int checks = 0;
    int errors = 0;
    int bus_cycles = 0;
    logic stb_q = 1'b0;

    aemb_dwb_lsu #(.DW(32), .TOW(4)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .req_ld_i  (req_ld_i),
        .req_st_i  (req_st_i),
        .req_adr_i (req_adr_i),
        .req_sel_i (req_sel_i),
        .req_dat_i (req_dat_i),
        .dwb_adr_o (dwb_adr_o),
        .dwb_sel_o (dwb_sel_o),
        .dwb_stb_o (dwb_stb_o),
        .dwb_wre_o (dwb_wre_o),
        .dwb_dat_o (dwb_dat_o),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_i (dwb_ack_i),
        .gena      (gena),
        .rDWBDI    (rDWBDI),
        .rDWBERR   (rDWBERR)
    );

    always #5 gclk = ~gclk;

    // Count strobe rising edges to detect duplicate bus cycles.
    always @(posedge gclk) begin
        if (dwb_stb_o && !stb_q) bus_cycles <= bus_cycles + 1;
        stb_q <= dwb_stb_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge gclk);
        #1;
    endtask

    task automatic set_req(input logic ld, input logic st, input logic [29:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        req_ld_i  = ld;
        req_st_i  = st;
        req_adr_i = adr;
        req_sel_i = sel;
        req_dat_i = dat;
    endtask

    task automatic zw_load(input string tag, input logic [29:0] adr, input logic [3:0] sel,
                           input logic [31:0] din, input logic [31:0] exp);
        set_req(1'b1, 1'b0, adr, sel, 32'd0);
        tick;
        check({tag, "_stb"}, 32'(dwb_stb_o), 32'd1);
        dwb_ack_i = 1'b1;
        dwb_dat_i = din;
        tick;
        dwb_ack_i = 1'b0;
        check({tag, "_data"}, rDWBDI, exp);
        check({tag, "_gena"}, 32'(gena), 32'd1);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        $display("TXN %s sel=%h din=%h rDWBDI=%h", tag, sel, din, rDWBDI);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int low;
        int bc0;

        grst      = 1'b1;
        dwb_ack_i = 1'b0;
        dwb_dat_i = 32'd0;
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        #12;
        check("rst_stb",  32'(dwb_stb_o), 32'd0);
        check("rst_wre",  32'(dwb_wre_o), 32'd0);
        check("rst_sel",  32'(dwb_sel_o), 32'd0);
        check("rst_adr",  32'(dwb_adr_o), 32'd0);
        check("rst_dato", dwb_dat_o, 32'd0);
        check("rst_gena", 32'(gena), 32'd1);
        check("rst_dbdi", rDWBDI, 32'd0);
        check("rst_err",  32'(rDWBERR), 32'd0);
        $display("TXN reset released");
        grst = 1'b0;
        tick;

        // Load byte, zero-wait slave
        set_req(1'b1, 1'b0, 30'h40, 4'h8, 32'd0);
        tick;
        check("t1_stb",  32'(dwb_stb_o), 32'd1);
        check("t1_gena", 32'(gena), 32'd0);
        check("t1_adr",  32'(dwb_adr_o), 32'h40);
        check("t1_sel",  32'(dwb_sel_o), 32'h8);
        check("t1_wre",  32'(dwb_wre_o), 32'd0);
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'hA1B2C3D4;
        tick;
        dwb_ack_i = 1'b0;
        check("t1_gena_up", 32'(gena), 32'd1);
        check("t1_stb_dn",  32'(dwb_stb_o), 32'd0);
        check("t1_data",    rDWBDI, 32'h000000A1);
        check("t1_err",     32'(rDWBERR), 32'd0);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        check("t1_idle_stb", 32'(dwb_stb_o), 32'd0);
        $display("TXN load byte adr=0x100 sel=8 rDWBDI=%h", rDWBDI);

        // Store half, three wait states
        set_req(1'b0, 1'b1, 30'h41, 4'h3, 32'h12345678);
        tick;
        check("t2_wre",  32'(dwb_wre_o), 32'd1);
        check("t2_dato", dwb_dat_o, 32'h56785678);
        check("t2_sel",  32'(dwb_sel_o), 32'h3);
        check("t2_stb",  32'(dwb_stb_o), 32'd1);
        low = (gena == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (gena == 1'b0) low++;
            check("t2_stb_hold", 32'(dwb_stb_o), 32'd1);
            check("t2_adr_hold", 32'(dwb_adr_o), 32'h41);
        end
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'hFFFFFFFF;
        tick;
        dwb_ack_i = 1'b0;
        if (gena == 1'b0) low++;
        check("t2_stall_cycles", 32'(low), 32'd4);
        check("t2_gena_up", 32'(gena), 32'd1);
        check("t2_stb_dn",  32'(dwb_stb_o), 32'd0);
        check("t2_dbdi_keep", rDWBDI, 32'h000000A1);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        $display("TXN store half sel=3 dat_o=%h stall=%0d", dwb_dat_o, low);

        // Timeout with no ack
        dwb_dat_i = 32'd0;
        set_req(1'b1, 1'b0, 30'h50, 4'hF, 32'd0);
        tick;
        n = 0;
        while (dwb_stb_o === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        check("t3_stb_cycles", 32'(n), 32'd15);
        check("t3_err",  32'(rDWBERR), 32'd1);
        check("t3_dbdi", rDWBDI, 32'd0);
        check("t3_gena", 32'(gena), 32'd1);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        check("t3_err_pulse", 32'(rDWBERR), 32'd0);
        check("t3_stb_idle",  32'(dwb_stb_o), 32'd0);
        $display("TXN timeout strobe_cycles=%0d", n);

        // Ack on the timeout edge
        set_req(1'b1, 1'b0, 30'h51, 4'hF, 32'd0);
        tick;
        repeat (14) tick;
        check("t4_stb_late", 32'(dwb_stb_o), 32'd1);
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'h11223344;
        tick;
        dwb_ack_i = 1'b0;
        check("t4_err",  32'(rDWBERR), 32'd0);
        check("t4_dbdi", rDWBDI, 32'h11223344);
        check("t4_stb",  32'(dwb_stb_o), 32'd0);
        check("t4_gena", 32'(gena), 32'd1);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        check("t4_err_after", 32'(rDWBERR), 32'd0);
        $display("TXN ack on timeout edge rDWBDI=%h", rDWBDI);

        // Back-to-back load word then store byte, requests held through DONE
        bc0 = bus_cycles;
        set_req(1'b1, 1'b0, 30'h60, 4'hF, 32'd0);
        tick;
        dwb_ack_i = 1'b1;
        dwb_dat_i = 32'hCAFEF00D;
        tick;
        dwb_ack_i = 1'b0;
        check("t5_ld_data", rDWBDI, 32'hCAFEF00D);
        tick;
        check("t5_no_dup", 32'(dwb_stb_o), 32'd0);
        set_req(1'b0, 1'b1, 30'h61, 4'h4, 32'h123456EE);
        tick;
        check("t5_st_stb",  32'(dwb_stb_o), 32'd1);
        check("t5_st_dato", dwb_dat_o, 32'hEEEEEEEE);
        check("t5_st_sel",  32'(dwb_sel_o), 32'h4);
        dwb_ack_i = 1'b1;
        tick;
        dwb_ack_i = 1'b0;
        check("t5_st_gena", 32'(gena), 32'd1);
        tick;
        check("t5_st_no_dup", 32'(dwb_stb_o), 32'd0);
        set_req(1'b1, 1'b0, 30'h62, 4'h0, 32'd0);
        repeat (3) begin
            tick;
            check("t5_fsl_stb", 32'(dwb_stb_o), 32'd0);
        end
        check("t5_fsl_gena", 32'(gena), 32'd1);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        tick;
        check("t5_bus_cycles", 32'(bus_cycles - bc0), 32'd2);
        $display("TXN back-to-back bus_cycles=%0d", bus_cycles - bc0);

        // Asynchronous reset in the middle of WAIT
        set_req(1'b1, 1'b0, 30'h70, 4'hF, 32'd0);
        tick;
        tick;
        check("t6_stb_wait", 32'(dwb_stb_o), 32'd1);
        #2 grst = 1'b1;
        #1;
        check("t6_stb",  32'(dwb_stb_o), 32'd0);
        check("t6_gena", 32'(gena), 32'd1);
        check("t6_sel",  32'(dwb_sel_o), 32'd0);
        check("t6_adr",  32'(dwb_adr_o), 32'd0);
        check("t6_wre",  32'(dwb_wre_o), 32'd0);
        check("t6_dbdi", rDWBDI, 32'd0);
        check("t6_err",  32'(rDWBERR), 32'd0);
        set_req(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        #1 grst = 1'b0;
        tick;
        $display("TXN async reset mid-wait");
        zw_load("t6_after", 30'h71, 4'hC, 32'hBEEF1234, 32'h0000BEEF);

        // Remaining load alignments, including an unsupported select
        zw_load("ld_sel2", 30'h80, 4'h2, 32'hA1B2C3D4, 32'h000000C3);
        zw_load("ld_sel1", 30'h81, 4'h1, 32'hA1B2C3D4, 32'h000000D4);
        zw_load("ld_sel4", 30'h82, 4'h4, 32'hA1B2C3D4, 32'h000000B2);
        zw_load("ld_sel3", 30'h83, 4'h3, 32'hA1B2C3D4, 32'h0000C3D4);
        zw_load("ld_sel5", 30'h84, 4'h5, 32'hA1B2C3D4, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
